// File: rtl/div_seq_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state codes, handshake levels,
// EX aluop codes for DIV/DIVU and the double register bus width.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam int DOUBLE_REG_BUS_W = 64;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU: one quotient bit per cycle,
// {remainder, quotient} presented with ready_o, stall requested while busy.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  div_state_e            state_reg, state_next;
  logic [2*DATA_W:0]     work_reg, work_next;
  logic [CNT_W-1:0]      counter_reg, counter_next;
  logic [DATA_W-1:0]     divisor_reg, divisor_next;
  logic                  a_sign_reg, a_sign_next;
  logic                  b_sign_reg, b_sign_next;
  logic [2*DATA_W-1:0]   result_reg, result_next;
  logic                  ready_reg, ready_next;

  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     abs_a, abs_b;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  // Trial subtraction of the divisor from the partial remainder; bit DATA_W is the borrow.
  assign diff = work_reg[2*DATA_W:DATA_W] - {1'b0, divisor_reg};

  assign abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Remainder follows the dividend sign; quotient is negative when the signs differ.
  assign quo_fix = (a_sign_reg ^ b_sign_reg) ? -work_reg[DATA_W-1:0] : work_reg[DATA_W-1:0];
  assign rem_fix = a_sign_reg ? -work_reg[2*DATA_W:DATA_W+1] : work_reg[2*DATA_W:DATA_W+1];

  always_comb begin
    state_next   = state_reg;
    work_next    = work_reg;
    counter_next = counter_reg;
    divisor_next = divisor_reg;
    a_sign_next  = a_sign_reg;
    b_sign_next  = b_sign_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;

    unique case (state_reg)
      DIV_FREE: begin
        ready_next  = DIV_RESULT_NOT_READY;
        result_next = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = DIV_BYZERO;
          end else begin
            a_sign_next  = signed_div_i & opdata1_i[DATA_W-1];
            b_sign_next  = signed_div_i & opdata2_i[DATA_W-1];
            divisor_next = abs_b;
            work_next    = {{DATA_W{1'b0}}, abs_a, 1'b0};
            counter_next = '0;
            state_next   = DIV_ON;
          end
        end
      end

      DIV_BYZERO: begin
        work_next  = '0;
        state_next = DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_next = DIV_FREE;
        end else if (counter_reg == CNT_W'(DATA_W)) begin
          work_next    = {rem_fix, work_reg[DATA_W], quo_fix};
          counter_next = '0;
          state_next   = DIV_END;
        end else begin
          if (diff[DATA_W])
            work_next = {work_reg[2*DATA_W-1:0], 1'b0};
          else
            work_next = {diff[DATA_W-1:0], work_reg[DATA_W-1:0], 1'b1};
          counter_next = counter_reg + CNT_W'(1);
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          state_next  = DIV_FREE;
          ready_next  = DIV_RESULT_NOT_READY;
          result_next = '0;
        end else begin
          ready_next  = DIV_RESULT_READY;
          result_next = {work_reg[2*DATA_W:DATA_W+1], work_reg[DATA_W-1:0]};
        end
      end

      default: state_next = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= DIV_FREE;
      work_reg    <= '0;
      counter_reg <= '0;
      divisor_reg <= '0;
      a_sign_reg  <= 1'b0;
      b_sign_reg  <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= DIV_RESULT_NOT_READY;
    end else begin
      state_reg   <= state_next;
      work_reg    <= work_next;
      counter_reg <= counter_next;
      divisor_reg <= divisor_next;
      a_sign_reg  <= a_sign_next;
      b_sign_reg  <= b_sign_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  assign result_o   = result_reg;
  assign ready_o    = ready_reg;
  assign stallreq_o = start_i & ~annul_i & ~ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: arithmetic reference model, per-cycle output checker,
// plus literal expectations for the documented corner cases.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  div_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;
  logic        cur_sgn;
  logic [31:0] cur_a, cur_b;

  // Reference: plain integer division, truncating toward zero (remainder takes dividend sign).
  function automatic logic [63:0] model(logic sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle checker: a visible result must equal the model, otherwise it must be zero.
  always @(negedge clk) begin
    if (chk_en) begin
      if (ready_o === 1'b1)
        check("result_vs_model", result_o, model(cur_sgn, cur_a, cur_b));
      else
        check("result_idle_zero", result_o, 64'd0);
      check("stallreq", {63'd0, stallreq_o}, {63'd0, start_i & ~annul_i & ~ready_o});
    end
  end

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_edges, input int hold,
                         output logic [63:0] res, output int stall_cnt);
    int edges;
    logic [63:0] first;
    cur_sgn = sgn; cur_a = a; cur_b = b;
    @(posedge clk); #1;
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    edges = -1; stall_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        opdata1_i = ~a; opdata2_i = b ^ 32'h5A5A_0001;
      end
      if (ready_o) begin edges = n; break; end
      if (stallreq_o) stall_cnt++;
    end
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    first = result_o;
    res = first;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
      check({tag, "_hold_result"}, result_o, first);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
    $display("[TB] %s sgn=%0d a=%h b=%h -> result=%h edges=%0d stall=%0d",
             tag, sgn, a, b, res, edges, stall_cnt);
  endtask

  logic [63:0] r;
  int          sc;
  int          edges;

  initial begin
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    cur_sgn = 1'b0; cur_a = '0; cur_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34, 0, r, sc);
    check("divu_100_7_lit", r, {32'd2, 32'd14});
    check("divu_100_7_stall", 64'(sc), 64'd34);

    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 0, r, sc);
    check("div_m7_2_lit", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 0, r, sc);
    check("div_7_m2_lit", r, {32'd1, 32'hFFFF_FFFD});

    run_div("div_by0", 1'b1, 32'd1234, 32'd0, 2, 0, r, sc);
    check("div_by0_lit", r, 64'd0);
    run_div("divu_by0", 1'b0, 32'hFFFF_FFFF, 32'd0, 2, 0, r, sc);
    check("divu_by0_lit", r, 64'd0);

    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, r, sc);
    check("div_ovf_lit", r, {32'd0, 32'h8000_0000});
    run_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, r, sc);
    check("divu_ovf_lit", r, {32'h8000_0000, 32'd0});

    run_div("divu_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 34, 0, r, sc);
    check("divu_max_3_lit", r, {32'd0, 32'h5555_5555});
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 5, r, sc);
    check("div_m100_m7_lit", r, {32'hFFFF_FFFE, 32'd14});
    run_div("divu_5_10", 1'b0, 32'd5, 32'd10, 34, 0, r, sc);
    check("divu_5_10_lit", r, {32'd5, 32'd0});

    // Annul at iteration 10 with start held: restart on the following edge with new operands.
    cur_sgn = 1'b0; cur_a = 32'd100; cur_b = 32'd7;
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    edges = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (n == 10) begin
        annul_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd9;
        cur_a = 32'd1000; cur_b = 32'd9;
        #1 check("annul_stall", {63'd0, stallreq_o}, 64'd0);
      end
      if (n == 11) annul_i = 1'b0;
      if (ready_o) begin edges = n; break; end
    end
    check("annul_latency", 64'(edges), 64'd46);
    check("annul_restart_lit", result_o, {32'd1, 32'd111});
    start_i = 1'b0;
    @(posedge clk); #1;
    check("annul_drop_ready", {63'd0, ready_o}, 64'd0);
    $display("[TB] annul at iter 10, restart 1000/9 -> result=%h edges=%0d", r, edges);

    // Reset mid-division at iteration 20, then a fresh division must take the full latency.
    cur_sgn = 1'b0; cur_a = 32'd77; cur_b = 32'd5;
    @(posedge clk); #1;
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_div("after_rst", 1'b0, 32'd77, 32'd5, 34, 0, r, sc);
    check("after_rst_lit", r, {32'd2, 32'd15});

    // Reset while the result is displayed: outputs must clear before any clock edge.
    cur_sgn = 1'b1; cur_a = 32'd9; cur_b = 32'd4;
    @(posedge clk); #1;
    signed_div_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd4; start_i = 1'b1;
    edges = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (ready_o) begin edges = n; break; end
    end
    check("end_rst_latency", 64'(edges), 64'd34);
    check("end_rst_lit", result_o, {32'd1, 32'd2});
    #1 rst = 1'b1;
    #1;
    check("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    $display("[TB] async reset in END -> ready=%0d result=%h", ready_o, result_o);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
